// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle data-memory handshake with byte-lane steering and load extension.
// Define LSU_TIMEOUT_EN to build the Mem_Ready watchdog that aborts a stuck access with Bus_Error.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [1:0]  data_size,
  input  logic        ext_type,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Load_Data,
  output logic        Stall,
  output logic        Misaligned,
  output logic        Bus_Error,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [3:0]  Mem_Be,
  output logic [31:0] Mem_Wdata,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Ready
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0] load_data_q, load_data_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        bus_error_q, bus_error_d;

  // Access attributes held for the whole transaction so load extraction
  // never depends on the core keeping its strobes stable while stalled.
  logic [1:0]  size_q,    size_d;
  logic [1:0]  lane_q,    lane_d;
  logic        ext_q,     ext_d;
  logic        is_load_q, is_load_d;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic        timeout_hit;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT must lie within 1..65535");
  end

  assign access  = Mem_Read | Mem_Write;
  assign is_byte = (data_size == 2'b01);
  assign is_half = (data_size == 2'b10);

  always_comb begin
    aligned = 1'b1;
    if (is_half) begin
      aligned = ~Addr[0];
    end else if (!is_byte) begin
      aligned = (Addr[1:0] == 2'b00);
    end
  end

  always_comb begin
    if (is_byte) begin
      be_req    = 4'b0001 << Addr[1:0];
      wdata_req = {4{Write_Data[7:0]}};
    end else if (is_half) begin
      be_req    = Addr[1] ? 4'b1100 : 4'b0011;
      wdata_req = {2{Write_Data[15:0]}};
    end else begin
      be_req    = '1;
      wdata_req = Write_Data;
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = Mem_Rdata[7:0];
      2'd1:    rd_byte = Mem_Rdata[15:8];
      2'd2:    rd_byte = Mem_Rdata[23:16];
      default: rd_byte = Mem_Rdata[31:24];
    endcase
    rd_half = lane_q[1] ? Mem_Rdata[31:16] : Mem_Rdata[15:0];
    if (size_q == 2'b01) begin
      load_ext = {{24{ext_q & rd_byte[7]}}, rd_byte};
    end else if (size_q == 2'b10) begin
      load_ext = {{16{ext_q & rd_half[15]}}, rd_half};
    end else begin
      load_ext = Mem_Rdata;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  assign timeout_hit = (state_q == REQ) && !Mem_Ready &&
                       (({1'b0, wait_cnt_q} + 17'd1) == TIMEOUT_LIM);

  // Holding the counter clear throughout IDLE is equivalent to clearing it on IDLE->REQ.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE) begin
      wait_cnt_d = '0;
    end else if (state_q == REQ && !Mem_Ready) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      bus_error_q <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      ext_q       <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      bus_error_q <= bus_error_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      ext_q       <= ext_d;
      is_load_q   <= is_load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && aligned) state_d = REQ;
      REQ:     if (Mem_Ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    lane_d      = lane_q;
    ext_d       = ext_q;
    is_load_d   = is_load_q;
    bus_error_d = 1'b0;
    Stall       = 1'b0;
    Misaligned  = 1'b0;
    case (state_q)
      IDLE: begin
        Misaligned = access & ~aligned;
        Stall      = access & aligned;
        if (access && aligned) begin
          mem_req_d   = 1'b1;
          mem_we_d    = Mem_Write;
          mem_addr_d  = {Addr[31:2], 2'b00};
          mem_be_d    = be_req;
          mem_wdata_d = wdata_req;
          size_d      = data_size;
          lane_d      = Addr[1:0];
          ext_d       = ext_type;
          is_load_d   = ~Mem_Write;
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (Mem_Ready) begin
          mem_req_d = 1'b0;
          if (is_load_q) load_data_d = load_ext;
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          if (is_load_q) load_data_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign Load_Data = load_data_q;
  assign Mem_Req   = mem_req_q;
  assign Mem_We    = mem_we_q;
  assign Mem_Addr  = mem_addr_q;
  assign Mem_Be    = mem_be_q;
  assign Mem_Wdata = mem_wdata_q;
  assign Bus_Error = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected request/response records, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_Read = 1'b0;
  logic        Mem_Write = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic        ext_type = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Write_Data = '0;
  logic [31:0] Load_Data;
  logic        Stall;
  logic        Misaligned;
  logic        Bus_Error;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [3:0]  Mem_Be;
  logic [31:0] Mem_Wdata;
  logic [31:0] Mem_Rdata = '0;
  logic        Mem_Ready = 1'b0;

  load_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .data_size(data_size), .ext_type(ext_type),
    .Addr(Addr), .Write_Data(Write_Data),
    .Load_Data(Load_Data), .Stall(Stall), .Misaligned(Misaligned), .Bus_Error(Bus_Error),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Be(Mem_Be), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Ready(Mem_Ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        berr;
    int          stalls;
  } exp_t;

  exp_t req_q[$];
  exp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    end
  endtask

  // Monitor: request fields on the Mem_Req rising edge, completion on its falling edge.
  logic prev_req = 1'b0;
  int   stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (Stall) stall_cnt++;
      if (Mem_Req && !prev_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got Mem_Addr 0x%08h expected no request", Mem_Addr);
        end else begin
          e = req_q.pop_front();
          chk("req_addr", Mem_Addr, e.addr);
          chk("req_we", 32'(Mem_We), 32'(e.we));
          chk("req_be", 32'(Mem_Be), 32'(e.be));
          chk("req_wdata", Mem_Wdata, e.wdata);
        end
      end
      if (!Mem_Req && prev_req) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = rsp_q.pop_front();
          chk("load_data", Load_Data, e.ldata);
          chk("bus_error", 32'(Bus_Error), 32'(e.berr));
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
      prev_req = Mem_Req;
    end
  end

  // Entered and left at posedge+1 with the FSM in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic ext,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int waits, input bit ready,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_ldata, input logic e_berr);
    exp_t e;
    e.addr = e_addr; e.we = wr; e.be = e_be; e.wdata = e_wdata;
    e.ldata = e_ldata; e.berr = e_berr;
    e.stalls = ready ? 2 + waits : 1 + waits;
    req_q.push_back(e);
    rsp_q.push_back(e);
    Mem_Read = rd; Mem_Write = wr; data_size = sz; ext_type = ext;
    Addr = addr; Write_Data = wd; Mem_Ready = 1'b0; Mem_Rdata = ~rdata;
    #1;
    chk("c0_stall", 32'(Stall), 32'd1);
    chk("c0_misaligned", 32'(Misaligned), 32'd0);
    @(posedge clk); #1;
    repeat (waits) begin @(posedge clk); #1; end
    if (ready) begin
      Mem_Ready = 1'b1; Mem_Rdata = rdata;
      @(posedge clk); #1;
    end
    Mem_Ready = 1'b0; Mem_Read = 1'b0; Mem_Write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic misaligned_access(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] addr, input logic [31:0] hold_ld);
    Mem_Read = rd; Mem_Write = wr; data_size = sz; Addr = addr; Write_Data = 32'h5A5A5A5A;
    #1;
    chk("mis_flag", 32'(Misaligned), 32'd1);
    chk("mis_stall", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    chk("mis_no_req", 32'(Mem_Req), 32'd0);
    chk("mis_hold_ld", Load_Data, hold_ld);
    Mem_Read = 1'b0; Mem_Write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1);
  end

  initial begin
    exp_t e;
    #2;
    chk("rst_load_data", Load_Data, 32'h0);
    chk("rst_mem_req", 32'(Mem_Req), 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'h0);
    chk("rst_mem_be", 32'(Mem_Be), 32'd0);
    chk("rst_bus_error", 32'(Bus_Error), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // rd wr size ext addr wdata rdata waits ready | addr be wdata ldata berr
    access(1, 0, 2'b11, 0, 32'h100, 32'hDEADBEEF, 32'h12345678, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h12345678, 0);
    access(1, 0, 2'b01, 1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
    access(1, 0, 2'b01, 0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 32'h100, 4'b1000, 32'h0, 32'h00000080, 0);
    access(0, 1, 2'b01, 0, 32'h202, 32'h000000AB, 32'h55555555, 0, 1, 32'h200, 4'b0100, 32'hABABABAB, 32'h00000080, 0);
    misaligned_access(1, 0, 2'b10, 32'h101, 32'h00000080);
    access(1, 0, 2'b10, 1, 32'h102, 32'h0, 32'h80017FFF, 2, 1, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 0);
    access(1, 0, 2'b10, 0, 32'h100, 32'h00005678, 32'h1234F00D, 0, 1, 32'h100, 4'b0011, 32'h56785678, 32'h0000F00D, 0);
    access(0, 1, 2'b10, 0, 32'h106, 32'h1234BEEF, 32'h0, 0, 1, 32'h104, 4'b1100, 32'hBEEFBEEF, 32'h0000F00D, 0);
    access(0, 1, 2'b11, 0, 32'h208, 32'hCAFEF00D, 32'h0, 1, 1, 32'h208, 4'b1111, 32'hCAFEF00D, 32'h0000F00D, 0);
    access(1, 1, 2'b00, 1, 32'h030, 32'h11223344, 32'hFFFFFFFF, 0, 1, 32'h030, 4'b1111, 32'h11223344, 32'h0000F00D, 0);
    access(1, 0, 2'b01, 1, 32'h101, 32'h000000C3, 32'h00007F00, 0, 1, 32'h100, 4'b0010, 32'hC3C3C3C3, 32'h0000007F, 0);
    misaligned_access(0, 1, 2'b11, 32'h202, 32'h0000007F);

    // No memory strobes: no stall, no flag, stray Mem_Ready ignored.
    data_size = 2'b10; Addr = 32'h101; Mem_Ready = 1'b1;
    #1;
    chk("nomem_stall", 32'(Stall), 32'd0);
    chk("nomem_misaligned", 32'(Misaligned), 32'd0);
    repeat (2) @(posedge clk);
    #1 Mem_Ready = 1'b0;
    chk("nomem_no_req", 32'(Mem_Req), 32'd0);

    // Mem_Ready on the TIMEOUT-th REQ cycle completes normally.
    access(1, 0, 2'b11, 0, 32'h104, 32'h0, 32'h0BADCAFE, 3, 1, 32'h104, 4'b1111, 32'h0, 32'h0BADCAFE, 0);
`ifdef LSU_TIMEOUT_EN
    access(1, 0, 2'b11, 0, 32'h108, 32'h0, 32'h77777777, TB_TIMEOUT, 0, 32'h108, 4'b1111, 32'h0, 32'h0, 1);
    chk("berr_one_cycle", 32'(Bus_Error), 32'd0);
`endif

    // Reset in REQ after three wait cycles.
    e.addr = 32'h400; e.we = 1'b0; e.be = 4'b1111; e.wdata = 32'h0;
    e.ldata = 32'h0; e.berr = 1'b0; e.stalls = 0;
    req_q.push_back(e);
    Mem_Read = 1'b1; data_size = 2'b11; Addr = 32'h400; Write_Data = 32'h0;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_req", 32'(Mem_Req), 32'd1);
    rst_n = 1'b0; Mem_Read = 1'b0;
    #1;
    chk("arst_mem_req", 32'(Mem_Req), 32'd0);
    chk("arst_mem_addr", Mem_Addr, 32'h0);
    chk("arst_mem_be", 32'(Mem_Be), 32'd0);
    chk("arst_load_data", Load_Data, 32'h0);
    chk("arst_stall", 32'(Stall), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 2'b11, 0, 32'h100, 32'h0, 32'hA5A5A5A5, 0, 1, 32'h100, 4'b1111, 32'h0, 32'hA5A5A5A5, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
